// File: rtl/ddfs_pkg.sv
// ddfs_pkg
//   Shared constants and the sweep-controller state type for the ddfs
//   frequency-sweep slice.
//   FCW_W         : width of the ddfs frequency control word
//   DWELL_W       : width of the per-value dwell counter
//   sweep_state_t : sequencer states (IDLE / DWELL / STEP / LAST)
package ddfs_pkg;

  localparam int FCW_W   = 23;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    LAST  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/ddfs_dwell_timer.sv
// ddfs_dwell_timer
//   Loadable down-counter. load_i places load_val_i in the counter; while
//   en_i is high the counter decrements toward zero and expire_o is high
//   during the cycle in which it reads zero. A load issued in the expiry
//   cycle starts the next dwell without a gap.
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load_i     in   load the counter (priority over counting)
//   en_i       in   count enable
//   load_val_i in   value to load (dwell length minus 1)
//   expire_o   out  counter is at zero while enabled
module ddfs_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// ddfs_sweep_ctrl
//   Frequency-sweep sequencer for the ddfs fcontrol input. Steps the
//   frequency word from a start value toward a stop value, holding each
//   value for cfg_dwell+1 cycles, then pulses done. abort mutes the output
//   and returns to IDLE from any state.
//   Build option: DDFS_SWEEP_BIDIR_EN enables a triangle sweep (up leg to
//   stop, then down leg back to start). Without it only the up leg is
//   produced and sweep_dir is tied low.
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   start          in   1-cycle sweep request, honoured in IDLE only
//   abort          in   stop sweep and mute output (highest priority)
//   cfg_start_fcw  in   first frequency word
//   cfg_stop_fcw   in   final frequency word
//   cfg_step_fcw   in   increment per step
//   cfg_dwell      in   hold time per value, cycles minus 1
//   fcontrol       out  frequency word to ddfs
//   busy           out  sweep in progress
//   done           out  1-cycle pulse on normal completion
//   sweep_dir      out  0 = up leg, 1 = down leg
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no sweep; fcontrol holds final value (or 0 after abort/reset)
// DWELL | holding an intermediate value; at expiry the step is taken
// STEP  | step decision; resolved combinationally in the expiry cycle
//       | of DWELL, so the state register never holds it
// LAST  | holding the final value; at expiry pulse done and go IDLE
module ddfs_sweep_ctrl #(
  parameter int FCW_W   = ddfs_pkg::FCW_W,
  parameter int DWELL_W = ddfs_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FCW_W-1:0]   cfg_start_fcw,
  input  logic [FCW_W-1:0]   cfg_stop_fcw,
  input  logic [FCW_W-1:0]   cfg_step_fcw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [FCW_W-1:0]   fcontrol,
  output logic               busy,
  output logic               done,
  output logic               sweep_dir
);

  import ddfs_pkg::*;

`ifdef DDFS_SWEEP_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  sweep_state_t       state_q, state_d;
  logic [FCW_W-1:0]   fcw_q, fcw_d;
  logic [FCW_W-1:0]   start_q, start_d;
  logic [FCW_W-1:0]   stop_q, stop_d;
  logic [FCW_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_expire;

  // One extra bit so an overflowing up step or an underflowing down step
  // is seen as reaching the end of the leg instead of wrapping.
  logic [FCW_W:0]     up_sum;
  logic [FCW_W:0]     dn_diff;
  logic               up_end;
  logic               dn_end;
  logic               cfg_degen;
  logic               going_down;

  assign up_sum     = {1'b0, fcw_q} + {1'b0, step_q};
  assign dn_diff    = {1'b0, fcw_q} - {1'b0, step_q};
  assign up_end     = (up_sum >= {1'b0, stop_q});
  assign dn_end     = dn_diff[FCW_W] || (dn_diff[FCW_W-1:0] <= start_q);
  assign cfg_degen  = (cfg_step_fcw == '0) || (cfg_start_fcw >= cfg_stop_fcw);

  // On the up leg fcontrol only equals stop after the clamp, so equality
  // marks the end of the stop dwell and the turn onto the down leg.
  assign going_down = BIDIR && (dir_q || (fcw_q == stop_q));

  ddfs_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .en_i       (busy),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    fcw_d    = fcw_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_q;

    if (abort) begin
      state_d = IDLE;
      fcw_d   = '0;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            start_d  = cfg_start_fcw;
            stop_d   = cfg_stop_fcw;
            step_d   = cfg_step_fcw;
            dwell_d  = cfg_dwell;
            fcw_d    = cfg_start_fcw;
            dir_d    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = cfg_dwell;
            state_d  = cfg_degen ? LAST : DWELL;
          end
        end
        DWELL: begin
          if (tmr_expire) begin
            tmr_load = 1'b1;
            if (going_down) begin
              dir_d = 1'b1;
              if (dn_end) begin
                fcw_d   = start_q;
                state_d = LAST;
              end else begin
                fcw_d = dn_diff[FCW_W-1:0];
              end
            end else if (up_end) begin
              fcw_d   = stop_q;
              // Triangle sweep still has the down leg ahead of it.
              state_d = BIDIR ? DWELL : LAST;
            end else begin
              fcw_d = up_sum[FCW_W-1:0];
            end
          end
        end
        LAST: begin
          if (tmr_expire) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dir_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcw_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign fcontrol = fcw_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef DDFS_SWEEP_BIDIR_EN
  assign sweep_dir = dir_q;
`else
  assign sweep_dir = 1'b0;
`endif

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// tb_ddfs_sweep_ctrl
//   Scoreboard bench for ddfs_sweep_ctrl. The driver issues sweeps and
//   pushes the expected per-cycle output sequence, built from the list of
//   frequency values a sweep should visit, into a queue; the monitor pops
//   one entry for every cycle in which the DUT shows busy or done.
module tb_ddfs_sweep_ctrl;

  localparam int    FW   = 23;
  localparam int    DW   = 16;
  localparam longint MAXV = 64'h7F_FFFF;
`ifdef DDFS_SWEEP_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] cfg_start_fcw = '0;
  logic [FW-1:0] cfg_stop_fcw = '0;
  logic [FW-1:0] cfg_step_fcw = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [FW-1:0] fcontrol;
  logic          busy;
  logic          done;
  logic          sweep_dir;

  ddfs_sweep_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_start_fcw (cfg_start_fcw),
    .cfg_stop_fcw  (cfg_stop_fcw),
    .cfg_step_fcw  (cfg_step_fcw),
    .cfg_dwell     (cfg_dwell),
    .fcontrol      (fcontrol),
    .busy          (busy),
    .done          (done),
    .sweep_dir     (sweep_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint fcw;
    bit     dir;
    bit     is_done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: list the values a sweep visits, then expand each into
  // dwell+1 busy cycles followed by one done cycle. limit >= 0 keeps only
  // the first limit busy cycles (sweep cut short by abort or reset).
  task automatic push_sweep(input longint s, input longint e, input longint st,
                            input int dw, input int limit,
                            output longint fin, output int n);
    longint vals[$];
    bit     dirs[$];
    longint v;
    exp_t   x;
    vals.push_back(s);
    dirs.push_back(1'b0);
    if (st != 0 && s < e) begin
      v = s;
      while (v < e) begin
        v = v + st;
        if (v > e) v = e;
        vals.push_back(v);
        dirs.push_back(1'b0);
      end
      if (BIDIR) begin
        while (v > s) begin
          v = v - st;
          if (v < s) v = s;
          vals.push_back(v);
          dirs.push_back(1'b1);
        end
      end
    end
    n = 0;
    for (int i = 0; i < vals.size(); i++) begin
      for (int k = 0; k <= dw; k++) begin
        if (limit < 0 || n < limit) begin
          x.fcw = vals[i];
          x.dir = dirs[i];
          x.is_done = 1'b0;
          exp_q.push_back(x);
          n++;
        end
      end
    end
    fin = vals[vals.size()-1];
    if (limit < 0) begin
      x.fcw = fin;
      x.dir = 1'b0;
      x.is_done = 1'b1;
      exp_q.push_back(x);
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (busy || done)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output busy=%0b done=%0b fcontrol=0x%0h required=idle at %0t",
                 busy, done, fcontrol, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done) begin
          check("done_pulse", longint'(done), 1);
          check("done_busy", longint'(busy), 0);
          check("done_fcontrol", longint'(fcontrol), mon_e.fcw);
        end else begin
          check("busy", longint'(busy), 1);
          check("early_done", longint'(done), 0);
          check("fcontrol", longint'(fcontrol), mon_e.fcw);
          check("sweep_dir", longint'(sweep_dir), longint'(mon_e.dir));
        end
      end
    end
  end

  task automatic launch(input longint s, input longint e, input longint st,
                        input int dw, input int limit,
                        output longint fin, output int n);
    @(negedge clk);
    cfg_start_fcw = FW'(s);
    cfg_stop_fcw  = FW'(e);
    cfg_step_fcw  = FW'(st);
    cfg_dwell     = DW'(dw);
    push_sweep(s, e, st, dw, limit, fin, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, input longint fin);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d_entries_left required=0", name, exp_q.size());
      exp_q.delete();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      @(negedge clk);
      check({name, "_idle_busy"}, longint'(busy), 0);
      check({name, "_idle_done"}, longint'(done), 0);
      check({name, "_hold_fcontrol"}, longint'(fcontrol), fin);
    end
  endtask

  task automatic full_sweep(input string name, input longint s, input longint e,
                            input longint st, input int dw);
    longint fin;
    int     n;
    launch(s, e, st, dw, -1, fin, n);
    drain(name, n + 8, fin);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    longint fin;
    int     n;
    longint s, e, st;
    int     dw, mode;

    #2;
    check("rst_fcontrol", longint'(fcontrol), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_dir", longint'(sweep_dir), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    full_sweep("s1", 1000, 1300, 100, 2);
    full_sweep("s2", 1000, 1250, 100, 0);
    full_sweep("s3", 64'h7FFF00, 64'h7FFFFF, 64'h200, 0);
    full_sweep("s5_equal", 500, 500, 10, 1);
    full_sweep("s5_step0", 700, 900, 0, 0);
    full_sweep("s5_inverted", 900, 700, 50, 2);

    // start pulsed and cfg changed while busy must not disturb the sweep
    launch(1000, 1300, 100, 1, -1, fin, n);
    cfg_start_fcw = FW'(5);
    cfg_stop_fcw  = FW'(9000);
    cfg_step_fcw  = FW'(7);
    cfg_dwell     = DW'(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("busy_start", n + 8, fin);

    // abort during the second cycle of the 1100 dwell
    launch(1000, 1300, 100, 2, 5, fin, n);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_fcontrol", longint'(fcontrol), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_dir", longint'(sweep_dir), 0);
    check("abort_queue", longint'(exp_q.size()), 0);
    cfg_start_fcw = FW'(1000);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", longint'(busy), 0);
    check("abort_start_fcontrol", longint'(fcontrol), 0);
    @(negedge clk);
    check("abort_start_busy2", longint'(busy), 0);

    // abort in the final dwell-expiry cycle suppresses done
    launch(1000, 1250, 100, 0, BIDIR ? 7 : 4, fin, n);
    repeat (n - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_done", longint'(done), 0);
    check("abort_last_busy", longint'(busy), 0);
    check("abort_last_fcontrol", longint'(fcontrol), 0);

    // asynchronous reset mid-sweep
    launch(1000, 1300, 100, 2, 4, fin, n);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fcontrol", longint'(fcontrol), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_dir", longint'(sweep_dir), 0);
    check("arst_queue", longint'(exp_q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", longint'(done), 0);

    for (int t = 0; t < 30; t++) begin
      mode = $urandom_range(0, 3);
      dw   = $urandom_range(0, 3);
      s    = longint'($urandom_range(0, 32'h7F_FFFF));
      if (mode == 2) begin
        s  = MAXV - longint'($urandom_range(0, 5000));
        e  = MAXV - longint'($urandom_range(0, 50));
        st = longint'($urandom_range(500, 6000));
      end else if (mode == 3) begin
        e  = (s > 200) ? s - longint'($urandom_range(0, 200)) : s;
        st = longint'($urandom_range(0, 300));
      end else begin
        e = s + longint'($urandom_range(0, 60000));
        if (e > MAXV) e = MAXV;
        st = (e - s) / longint'($urandom_range(1, 10)) + longint'($urandom_range(0, 3));
      end
      full_sweep("rand", s, e, st, dw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
